// File: rtl/cpu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_arbiter_if
// Description : Bundle of every non-clock/reset signal of cpu_wb_arbiter.
//               The slave modport is the arbiter's view; the master modport
//               is the view of the pipeline (execute unit, load unit, issue
//               stage and register file) that surrounds it.
// Signals     : ex_valid_i/ex_ready_o, ex_rd_i, ex_data_i     execute writeback
//               mem_valid_i/mem_ready_o, mem_rd_i, mem_data_i load writeback
//               issue_i, issue_rd_i                           issue marks rd pending
//               rs0_addr_i, rs1_addr_i, stall_o               operand hazard check
//               busy_o                                        pending-write scoreboard
//               write_addr_o, write_data_o, write_enable_o    register-file write
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_wb_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
);
    logic                      ex_valid_i;
    logic                      ex_ready_o;
    logic [AddrWidth-1:0]      ex_rd_i;
    logic [DataWidth-1:0]      ex_data_i;
    logic                      mem_valid_i;
    logic                      mem_ready_o;
    logic [AddrWidth-1:0]      mem_rd_i;
    logic [DataWidth-1:0]      mem_data_i;
    logic                      issue_i;
    logic [AddrWidth-1:0]      issue_rd_i;
    logic [AddrWidth-1:0]      rs0_addr_i;
    logic [AddrWidth-1:0]      rs1_addr_i;
    logic                      stall_o;
    logic [2**AddrWidth-1:0]   busy_o;
    logic [AddrWidth-1:0]      write_addr_o;
    logic [DataWidth-1:0]      write_data_o;
    logic                      write_enable_o;

    modport slave (
        input  ex_valid_i, ex_rd_i, ex_data_i,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        input  issue_i, issue_rd_i, rs0_addr_i, rs1_addr_i,
        output ex_ready_o, mem_ready_o, stall_o, busy_o,
        output write_addr_o, write_data_o, write_enable_o
    );

    modport master (
        output ex_valid_i, ex_rd_i, ex_data_i,
        output mem_valid_i, mem_rd_i, mem_data_i,
        output issue_i, issue_rd_i, rs0_addr_i, rs1_addr_i,
        input  ex_ready_o, mem_ready_o, stall_o, busy_o,
        input  write_addr_o, write_data_o, write_enable_o
    );
endinterface
`default_nettype wire

// File: rtl/cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_wb_arbiter
// Description : Arbitrates register-file writeback between the execute unit
//               (requester 0) and the load unit (requester 1) using a 1-bit
//               round-robin pointer that only moves on contested cycles.
//               The granted result reaches the register-file write port one
//               cycle after the handshake. A pending-write scoreboard is set
//               at issue, cleared at writeback, and drives the operand stall.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - cpu_wb_arbiter_if.slave (handshakes, scoreboard,
//                          register-file write port)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_wb_arbiter #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_wb_arbiter_if.slave       bus
);

    localparam int NumRegs = 2 ** AddrWidth;

    // Round-robin pointer: 0 favours execute, 1 favours load.
    logic                  ptr_q, ptr_d;
    logic [NumRegs-1:0]    busy_q, busy_d;
    logic                  we_q, we_d;
    logic [AddrWidth-1:0]  waddr_q, waddr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;

    logic                  w_both;
    logic                  w_ex_grant;
    logic                  w_mem_grant;
    logic                  w_xfer;
    logic [AddrWidth-1:0]  w_rd;
    logic [DataWidth-1:0]  w_data;
    logic                  w_wr;

    // Grants are gated by reset_n so nothing handshakes while reset is held.
    assign w_both      = bus.ex_valid_i & bus.mem_valid_i;
    assign w_ex_grant  = reset_n & bus.ex_valid_i  & (~bus.mem_valid_i | ~ptr_q);
    assign w_mem_grant = reset_n & bus.mem_valid_i & (~bus.ex_valid_i  |  ptr_q);
    assign w_xfer      = w_ex_grant | w_mem_grant;
    assign w_rd        = w_ex_grant ? bus.ex_rd_i   : bus.mem_rd_i;
    assign w_data      = w_ex_grant ? bus.ex_data_i : bus.mem_data_i;
    // Writes to register 0 complete the handshake but are otherwise discarded.
    assign w_wr        = w_xfer & (w_rd != '0);

    always_comb begin
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        we_d    = w_wr;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (w_both) begin
            ptr_d = ~ptr_q;
        end

        if (w_wr) begin
            waddr_d        = w_rd;
            wdata_d        = w_data;
            busy_d[w_rd]   = 1'b0;
        end

        // Applied after the clear so a same-cycle issue to the register being
        // written back keeps it pending for the newer producer.
        if (bus.issue_i && (bus.issue_rd_i != '0)) begin
            busy_d[bus.issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= 1'b0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.ex_ready_o     = w_ex_grant;
    assign bus.mem_ready_o    = w_mem_grant;
    assign bus.busy_o         = busy_q;
    // Register 0 is never marked busy, so it never stalls; no bypass from the
    // writeback in flight this cycle.
    assign bus.stall_o        = busy_q[bus.rs0_addr_i] | busy_q[bus.rs1_addr_i];
    assign bus.write_enable_o = we_q;
    assign bus.write_addr_o   = waddr_q;
    assign bus.write_data_o   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_wb_arbiter
// Description : Self-checking bench for cpu_wb_arbiter: directed scenarios
//               followed by randomized traffic compared against a reference
//               model of grants, scoreboard and write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2 ** AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cpu_wb_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    cpu_wb_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NR-1:0] m_busy;
    bit            m_turn_mem;   // 1: load unit wins the next contested cycle
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic drive_idle();
        bus.ex_valid_i  = 1'b0; bus.ex_rd_i  = '0; bus.ex_data_i  = '0;
        bus.mem_valid_i = 1'b0; bus.mem_rd_i = '0; bus.mem_data_i = '0;
        bus.issue_i     = 1'b0; bus.issue_rd_i = '0;
        bus.rs0_addr_i  = '0;   bus.rs1_addr_i = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd3; bus.ex_data_i = 32'h1234_5678;
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd4;
        repeat (2) @(negedge clk);
        checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.write_enable_o); end
        checks++; if (bus.write_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.write_addr_o); end
        checks++; if (bus.write_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.write_data_o); end
        checks++; if (bus.busy_o !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy_o); end
        drive_idle();
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL reset_release_we: got %b expected 0", bus.write_enable_o); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd5; bus.ex_data_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.ex_ready_o !== 1'b1 || bus.mem_ready_o !== 1'b0) begin errors++; $display("FAIL single_ready: got ex=%b mem=%b expected ex=1 mem=0", bus.ex_ready_o, bus.mem_ready_o); end
        @(negedge clk);
        drive_idle();
        checks++; if (bus.write_enable_o !== 1'b1 || bus.write_addr_o !== 5'd5 || bus.write_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=5 data=deadbeef", bus.write_enable_o, bus.write_addr_o, bus.write_data_o); end
        checks++; if (bus.busy_o !== '0) begin errors++; $display("FAIL single_busy: got %h expected 0", bus.busy_o); end
        @(negedge clk);
        checks++; if (bus.write_enable_o !== 1'b0 || bus.write_addr_o !== 5'd5 || bus.write_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold: got we=%b addr=%0d data=%h expected we=0 addr=5 data=deadbeef", bus.write_enable_o, bus.write_addr_o, bus.write_data_o); end
    endtask

    task automatic test_contention();
        int exp_g [3] = '{0, 1, 0};
        logic [AW-1:0] ea;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                ea = (exp_g[i-1] == 0) ? 5'd1 : 5'd2;
                checks++; if (bus.write_enable_o !== 1'b1 || bus.write_addr_o !== ea) begin errors++; $display("FAIL contention_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i-1, bus.write_enable_o, bus.write_addr_o, ea); end
            end
            if (i < 3) begin
                bus.ex_valid_i  = 1'b1; bus.ex_rd_i  = 5'd1; bus.ex_data_i  = 32'hAAAA_0001;
                bus.mem_valid_i = 1'b1; bus.mem_rd_i = 5'd2; bus.mem_data_i = 32'hBBBB_0002;
                #1;
                checks++; if (bus.ex_ready_o !== (exp_g[i] == 0) || bus.mem_ready_o !== (exp_g[i] == 1)) begin errors++; $display("FAIL contention_grant[%0d]: got ex=%b mem=%b expected requester %0d", i, bus.ex_ready_o, bus.mem_ready_o, exp_g[i]); end
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd7;
        @(negedge clk);
        bus.issue_i = 1'b0; bus.rs0_addr_i = 5'd7;
        bus.mem_valid_i = 1'b1; bus.mem_rd_i = 5'd7; bus.mem_data_i = 32'h0000_0777;
        #1;
        checks++; if (bus.busy_o !== 32'h0000_0080) begin errors++; $display("FAIL sb_busy_set: got %h expected 00000080", bus.busy_o); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL sb_stall_nobypass: got %b expected 1", bus.stall_o); end
        checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL sb_mem_ready: got %b expected 1", bus.mem_ready_o); end
        @(negedge clk);
        bus.mem_valid_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.busy_o !== '0) begin errors++; $display("FAIL sb_clear: got stall=%b busy=%h expected stall=0 busy=0", bus.stall_o, bus.busy_o); end
        checks++; if (bus.write_enable_o !== 1'b1 || bus.write_addr_o !== 5'd7) begin errors++; $display("FAIL sb_write: got we=%b addr=%0d expected we=1 addr=7", bus.write_enable_o, bus.write_addr_o); end
        drive_idle();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd9;
        @(negedge clk);
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd9; bus.ex_data_i = 32'h0909_0909;
        @(negedge clk);
        drive_idle();
        bus.rs1_addr_i = 5'd9;
        #1;
        checks++; if (bus.busy_o !== 32'h0000_0200) begin errors++; $display("FAIL simul_busy: got %h expected 00000200", bus.busy_o); end
        checks++; if (bus.write_enable_o !== 1'b1 || bus.write_addr_o !== 5'd9 || bus.write_data_o !== 32'h0909_0909) begin errors++; $display("FAIL simul_write: got we=%b addr=%0d data=%h expected we=1 addr=9 data=09090909", bus.write_enable_o, bus.write_addr_o, bus.write_data_o); end
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL simul_stall: got %b expected 1", bus.stall_o); end
        drive_idle();
    endtask

    task automatic test_x0();
        apply_reset();
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd0; bus.ex_data_i = 32'hFFFF_FFFF;
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd0;
        #1;
        checks++; if (bus.ex_ready_o !== 1'b1 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL x0_ready_stall: got ready=%b stall=%b expected ready=1 stall=0", bus.ex_ready_o, bus.stall_o); end
        @(negedge clk);
        drive_idle();
        checks++; if (bus.write_enable_o !== 1'b0 || bus.busy_o !== '0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL x0_effect: got we=%b busy=%h stall=%b expected we=0 busy=0 stall=0", bus.write_enable_o, bus.busy_o, bus.stall_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd7;
        @(negedge clk);
        bus.issue_rd_i = 5'd1;
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd3; bus.ex_data_i = 32'h3333_3333;
        @(negedge clk);
        bus.issue_i = 1'b0;
        bus.ex_rd_i = 5'd4; bus.ex_data_i = 32'h4444_4444;
        #1;
        checks++; if (bus.busy_o !== 32'h0000_0082 || bus.write_enable_o !== 1'b1) begin errors++; $display("FAIL rmid_pre: got busy=%h we=%b expected busy=00000082 we=1", bus.busy_o, bus.write_enable_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== '0 || bus.write_enable_o !== 1'b0 || bus.write_addr_o !== '0 || bus.write_data_o !== '0) begin errors++; $display("FAIL rmid_async: got busy=%h we=%b addr=%0d data=%h expected all 0", bus.busy_o, bus.write_enable_o, bus.write_addr_o, bus.write_data_o); end
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.write_enable_o !== 1'b0 || bus.busy_o !== '0) begin errors++; $display("FAIL rmid_after: got we=%b busy=%h expected we=0 busy=0", bus.write_enable_o, bus.busy_o); end
    endtask

    task automatic test_random();
        bit ex_hold = 0;
        bit mem_hold = 0;
        bit g_ex, g_mem;
        logic [AW-1:0] rd;
        apply_reset();
        m_busy = '0; m_turn_mem = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++; if (bus.write_enable_o !== m_we) begin errors++; $display("FAIL rnd_we cycle %0d: got %b expected %b", i, bus.write_enable_o, m_we); end
            checks++; if (bus.write_addr_o !== m_addr || bus.write_data_o !== m_data) begin errors++; $display("FAIL rnd_port cycle %0d: got addr=%0d data=%h expected addr=%0d data=%h", i, bus.write_addr_o, bus.write_data_o, m_addr, m_data); end
            checks++; if (bus.busy_o !== m_busy) begin errors++; $display("FAIL rnd_busy cycle %0d: got %h expected %h", i, bus.busy_o, m_busy); end

            if (!ex_hold) begin
                bus.ex_valid_i = 1'($urandom_range(0, 1));
                bus.ex_rd_i    = AW'($urandom_range(0, 7));
                bus.ex_data_i  = $urandom;
            end
            if (!mem_hold) begin
                bus.mem_valid_i = 1'($urandom_range(0, 1));
                bus.mem_rd_i    = AW'($urandom_range(0, 7));
                bus.mem_data_i  = $urandom;
            end
            bus.issue_i    = ($urandom_range(0, 2) == 0);
            bus.issue_rd_i = AW'($urandom_range(0, 7));
            bus.rs0_addr_i = AW'($urandom_range(0, 7));
            bus.rs1_addr_i = AW'($urandom_range(0, 7));
            #1;

            // A lone requester always wins; on contention the turn decides and passes on.
            if (bus.ex_valid_i && bus.mem_valid_i) begin
                g_mem = m_turn_mem;
                g_ex  = !m_turn_mem;
                m_turn_mem = !m_turn_mem;
            end else begin
                g_ex  = bus.ex_valid_i;
                g_mem = bus.mem_valid_i;
            end

            checks++; if (bus.ex_ready_o !== g_ex || bus.mem_ready_o !== g_mem) begin errors++; $display("FAIL rnd_grant cycle %0d: got ex=%b mem=%b expected ex=%b mem=%b", i, bus.ex_ready_o, bus.mem_ready_o, g_ex, g_mem); end
            checks++; if (bus.stall_o !== (m_busy[bus.rs0_addr_i] | m_busy[bus.rs1_addr_i])) begin errors++; $display("FAIL rnd_stall cycle %0d: got %b expected %b", i, bus.stall_o, m_busy[bus.rs0_addr_i] | m_busy[bus.rs1_addr_i]); end

            m_we = 1'b0;
            if (g_ex || g_mem) begin
                rd = g_ex ? bus.ex_rd_i : bus.mem_rd_i;
                if (rd != 0) begin
                    m_busy[rd] = 1'b0;
                    m_we   = 1'b1;
                    m_addr = rd;
                    m_data = g_ex ? bus.ex_data_i : bus.mem_data_i;
                end
            end
            if (bus.issue_i && bus.issue_rd_i != 0) m_busy[bus.issue_rd_i] = 1'b1;
            ex_hold  = bus.ex_valid_i  && !g_ex;
            mem_hold = bus.mem_valid_i && !g_mem;
        end
        @(negedge clk);
        drive_idle();
        checks++; if (bus.write_enable_o !== m_we || bus.busy_o !== m_busy) begin errors++; $display("FAIL rnd_final: got we=%b busy=%h expected we=%b busy=%h", bus.write_enable_o, bus.busy_o, m_we, m_busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_simultaneous();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
